// File: rtl/ifetch.sv
// Instruction fetch unit.
// Issues one read at a time to instruction memory at the current PC. It gives
// the PC a one-cycle advance permit on each grant and queues returned words in
// a small FIFO toward decode. A redirect flushes the queue and drops any
// response still in flight.
// Build option: define IFETCH_PREFETCH_EN for a 2-entry buffer, so the next
// fetch overlaps a decode stall. Without it the buffer has 1 entry.
module ifetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_addr,
  input  logic        redirect,
  output logic        pc_adv,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready
);

`ifdef IFETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [1:0]      CNT_MAX  = 2'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_KILL = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             go_q;
  logic [15:0]      addr_q;
  logic [1:0]       count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [15:0]      data_mem [DEPTH];
  logic [15:0]      pc_mem   [DEPTH];
  logic             push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = addr_q;
  assign pc_adv      = imem_req & imem_gnt & ~redirect;
  assign instr_valid = (count_q != 2'd0);
  // A redirect cancels both a pop and a push in the same cycle.
  assign pop         = instr_valid & instr_ready & ~redirect;
  assign push        = (state_q == S_WAIT) & imem_rvalid & ~redirect;
  assign instr       = instr_valid ? data_mem[rd_ptr_q] : 16'h0000;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr_q]   : 16'h0000;

  // Buffer occupancy after this cycle's push, pop and flush.
  always_comb begin
    // NOTE: every always_comb output is given a default first, so no path leaves it unassigned and no latch is inferred.
    count_d = count_q;
    if (redirect)
      count_d = 2'd0;
    else if (push && !pop)
      count_d = count_q + 2'd1;
    else if (pop && !push)
      count_d = count_q - 2'd1;
  end

  // Fetch FSM next state. A new request is only started when it still fits in the buffer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (go_q && !redirect && (count_q < CNT_MAX))
          state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect)
          state_d = imem_gnt ? S_KILL : S_IDLE;
        else if (imem_gnt)
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (redirect)
          state_d = imem_rvalid ? S_IDLE : S_KILL;
        else if (imem_rvalid)
          state_d = (count_d < CNT_MAX) ? S_REQ : S_IDLE;
      end
      S_KILL: begin
        // Stay here until the flushed response arrives, even across further
        // redirects. Once it has arrived nothing is outstanding, so we leave.
        if (imem_rvalid)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers: FSM, post-reset start gate, fetch address, FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      go_q     <= 1'b0;
      addr_q   <= 16'h0000;
      count_q  <= 2'd0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register here samples pre-edge values.
      state_q <= state_d;
      // Holds off the first request until the second edge after reset.
      go_q    <= 1'b1;
      count_q <= count_d;
      if ((state_d == S_REQ) && (state_q != S_REQ))
        addr_q <= pc_addr;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (pop)
          rd_ptr_q <= ptr_inc(rd_ptr_q);
        if (push)
          wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
    end
  end

  // Buffer storage: each push writes the returned word and the address it came from.
  // NOTE: storage is not reset on purpose. instr/instr_pc read as zero while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]   <= addr_q;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch. The bench models the CPU PC and a memory
// with random grant and latency. The reference model tracks the
// architectural instruction stream and the buffer occupancy.
module tb_ifetch;

`ifdef IFETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc_addr;
  logic        redirect;
  logic        pc_adv;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;

  always #5 clk = ~clk;

  ifetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_addr    (pc_addr),
    .redirect   (redirect),
    .pc_adv     (pc_adv),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready)
  );

  int vectors = 0;
  int miscompares = 0;

  // Environment and reference model state.
  logic [15:0] pc;
  logic [15:0] exp_pc;
  logic [15:0] redir_tgt;
  logic [15:0] force_tgt;
  logic [15:0] mem_a;
  logic [15:0] prev_iaddr;
  int          buffered, mem_wait, lat_min, lat_max;
  int          gnt_pct, ready_pct, redir_pml;
  int          grants_live, adv_count, consumed;
  bit          mem_busy, mem_live, mem_dead, dead_on_kill;
  bit          force_redir, arm_rv_redir, rv_redir_hit;
  bit          prev_redir, prev_req_stay, watch_dead, saw_dead;
  logic [15:0] cons_q[$];

  // Values sampled mid-cycle.
  logic        s_req, s_gnt, s_redir, s_valid, s_ready, s_adv;
  logic [15:0] s_ipc, s_iaddr;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'd40503) ^ 16'h3C5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle from a negedge. Sample and check 1 time unit later,
  // update the models at the posedge, and return at the next negedge.
  task automatic cycle();
    pc_addr     = pc;
    imem_rvalid = mem_busy && (mem_wait == 0);
    imem_rdata  = imem_rvalid ? (mem_dead ? 16'hDEAD : mem_word(mem_a)) : 16'($urandom);
    imem_gnt    = imem_req && !mem_busy && (int'($urandom_range(99)) < gnt_pct);
    instr_ready = int'($urandom_range(99)) < ready_pct;
    redirect    = 1'b0;
    redir_tgt   = 16'($urandom);
    if ($urandom_range(3) == 0)
      redir_tgt = 16'hFFFD + 16'($urandom_range(2));
    if (force_redir) begin
      redirect    = 1'b1;
      redir_tgt   = force_tgt;
      force_redir = 1'b0;
    end else if (arm_rv_redir && imem_rvalid && (instr_valid || DEPTH == 1)) begin
      redirect     = 1'b1;
      instr_ready  = 1'b1;
      arm_rv_redir = 1'b0;
      rv_redir_hit = 1'b1;
    end else if (int'($urandom_range(999)) < redir_pml) begin
      redirect = 1'b1;
    end
    #1;
    s_req = imem_req;  s_gnt = imem_gnt;  s_redir = redirect;
    s_valid = instr_valid;  s_ready = instr_ready;  s_adv = pc_adv;
    s_ipc = instr_pc;  s_iaddr = imem_addr;

    check("pc_adv", s_adv, s_gnt && !s_redir);
    check("valid_vs_model", s_valid, buffered > 0);
    if (prev_redir)
      check("valid_after_redirect", s_valid, 1'b0);
    if (buffered >= DEPTH)
      check("no_req_when_full", s_req, 1'b0);
    if (prev_req_stay) begin
      check("req_held", s_req, 1'b1);
      check("req_addr_stable", s_iaddr, prev_iaddr);
    end
    if (s_gnt && !s_redir)
      check("fetch_addr", s_iaddr, pc);
    if (s_valid && s_ready && !s_redir) begin
      check("instr_pc", s_ipc, exp_pc);
      check("instr", instr, mem_word(exp_pc));
    end
    if (watch_dead && s_valid && instr === 16'hDEAD)
      saw_dead = 1'b1;

    @(posedge clk);
    if (s_valid && s_ready && !s_redir) begin
      buffered--;
      consumed++;
      cons_q.push_back(s_ipc);
      exp_pc = exp_pc + 16'd1;
    end
    if (mem_busy) begin
      if (mem_wait == 0) begin
        mem_busy = 1'b0;
        if (mem_live && !s_redir)
          buffered++;
      end else begin
        mem_wait--;
      end
    end
    if (s_redir && mem_busy) begin
      mem_live = 1'b0;
      if (dead_on_kill)
        mem_dead = 1'b1;
    end
    if (s_gnt) begin
      mem_busy = 1'b1;
      mem_a    = s_iaddr;
      mem_wait = $urandom_range(lat_max, lat_min);
      mem_live = !s_redir;
      mem_dead = 1'b0;
      if (!s_redir)
        grants_live++;
    end
    if (s_adv)
      adv_count++;
    if (s_redir) begin
      pc       = redir_tgt;
      exp_pc   = redir_tgt;
      buffered = 0;
    end else if (s_adv) begin
      pc = pc + 16'd1;
    end
    prev_redir    = s_redir;
    prev_req_stay = s_req && !s_gnt && !s_redir;
    prev_iaddr    = s_iaddr;
    @(negedge clk);
  endtask

  // Assert reset asynchronously and check that the outputs clear at once.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_pc_adv", pc_adv, 1'b0);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_imem_addr", imem_addr, 16'h0000);
    check("rst_instr", instr, 16'h0000);
    check("rst_instr_pc", instr_pc, 16'h0000);
    buffered      = 0;
    mem_live      = 1'b0;
    prev_redir    = 1'b0;
    prev_req_stay = 1'b0;
    exp_pc        = pc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit          got;
    int          g0, c0;
    logic [15:0] a;

    rst_n = 1'b0;  pc = 16'h0000;  pc_addr = 16'h0000;  redirect = 1'b0;
    imem_gnt = 1'b0;  imem_rvalid = 1'b0;  imem_rdata = 16'h0000;  instr_ready = 1'b0;
    exp_pc = 16'h0000;  buffered = 0;  mem_wait = 0;  mem_busy = 1'b0;  mem_live = 1'b0;
    mem_dead = 1'b0;  dead_on_kill = 1'b0;  force_redir = 1'b0;  arm_rv_redir = 1'b0;
    rv_redir_hit = 1'b0;  prev_redir = 1'b0;  prev_req_stay = 1'b0;  watch_dead = 1'b0;
    saw_dead = 1'b0;  grants_live = 0;  adv_count = 0;  consumed = 0;
    force_tgt = 16'h0000;  mem_a = 16'h0000;  prev_iaddr = 16'h0000;
    gnt_pct = 100;  ready_pct = 100;  redir_pml = 0;  lat_min = 0;  lat_max = 0;

    // Reset state, then release with immediate grant and 1-cycle response.
    @(negedge clk);
    do_reset();
    cycle();
    rst_n = 1'b1;
    cycle();
    check("req_before_edge1", s_req, 1'b0);
    cycle();
    check("req_before_edge2", s_req, 1'b0);
    repeat (24) cycle();
    check("b_three_beats", consumed >= 3, 1'b1);
    if (consumed >= 3) begin
      check("b_pc0", cons_q[0], 16'h0000);
      check("b_pc1", cons_q[1], 16'h0001);
      check("b_pc2", cons_q[2], 16'h0002);
    end
    check("b_adv_per_grant", adv_count, grants_live);

    // Decode stall: from a flushed buffer, exactly DEPTH fetches, then the request stays low.
    ready_pct   = 0;
    force_redir = 1'b1;
    force_tgt   = 16'h0200;
    cycle();
    g0 = grants_live;
    repeat (14) cycle();
    check("c_stall_fetches", grants_live - g0, DEPTH);
    repeat (5) begin
      cycle();
      check("c_stall_req_low", s_req, 1'b0);
      check("c_stall_adv_low", s_adv, 1'b0);
      check("c_stall_valid", s_valid, 1'b1);
    end
    ready_pct = 100;

    // Redirect while waiting for data; the late 16'hDEAD response must be dropped.
    lat_min = 2;  lat_max = 2;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      cycle();
      if (s_gnt && !s_redir) got = 1'b1;
    end
    check("d_grant_seen", got, 1'b1);
    force_redir  = 1'b1;
    force_tgt    = 16'h0040;
    dead_on_kill = 1'b1;
    watch_dead   = 1'b1;
    saw_dead     = 1'b0;
    cycle();
    for (int i = 0; i < 10 && mem_busy; i++) begin
      cycle();
      check("d_kill_no_req", s_req, 1'b0);
      check("d_kill_no_valid", s_valid, 1'b0);
    end
    dead_on_kill = 1'b0;
    got = 1'b0;
    a   = 16'hFFFF;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      if (s_gnt) begin got = 1'b1; a = s_iaddr; end
    end
    check("d_refetch_addr", a, 16'h0040);
    repeat (8) cycle();
    watch_dead = 1'b0;
    check("d_dead_never_shown", saw_dead, 1'b0);

    // Redirect together with a response (and a pop when one is pending).
    lat_min = 0;  lat_max = 1;  ready_pct = 40;
    arm_rv_redir = 1'b1;
    rv_redir_hit = 1'b0;
    for (int i = 0; i < 400 && !rv_redir_hit; i++) cycle();
    arm_rv_redir = 1'b0;
    check("e_coincide_hit", rv_redir_hit, 1'b1);
    cycle();
    check("e_empty_after", s_valid, 1'b0);
    ready_pct = 100;

    // Address wrap: FFFF is fetched, then 0000.
    force_redir = 1'b1;
    force_tgt   = 16'hFFFF;
    cycle();
    c0 = consumed;
    for (int i = 0; i < 40 && consumed < c0 + 2; i++) cycle();
    check("f_two_beats", consumed >= c0 + 2, 1'b1);
    if (consumed >= c0 + 2) begin
      check("f_pc_ffff", cons_q[c0], 16'hFFFF);
      check("f_pc_wrap", cons_q[c0 + 1], 16'h0000);
    end

    // Reset while waiting for data; the late response must not appear.
    lat_min = 4;  lat_max = 4;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      cycle();
      if (s_gnt && !s_redir) got = 1'b1;
    end
    check("g_grant_seen", got, 1'b1);
    pc = 16'h0100;
    do_reset();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 20 && mem_busy; i++) cycle();
    repeat (2) begin
      cycle();
      check("g_no_valid_after_late_rvalid", s_valid, 1'b0);
    end

    // Random soak.
    lat_min = 0;  lat_max = 3;  gnt_pct = 60;  ready_pct = 70;  redir_pml = 30;
    repeat (2500) cycle();
    redir_pml = 0;
    repeat (20) cycle();
    check("h_adv_equals_grants", adv_count, grants_live);
    check("h_progress", consumed > 100, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
